lsu_dmem_ctrl: RTL

Load/store controller sitting directly upstream of the single-port data memory, between the core's memory stage and the RAM. It turns byte, halfword and word load/store requests into word-wide RAM accesses. It accounts for the RAM's one-cycle registered read latency. Sub-word stores are done as read-modify-write, and load data is extracted and sign- or zero-extended.

---
 rtl/lsu_dmem_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_dmem_ctrl
//
// Load/store controller in front of a single-port, word-wide data RAM with a
// one-cycle registered read. Converts byte/half/word requests from the memory
// stage into word RAM accesses: word stores write directly, sub-word stores
// are read-modify-write, loads are lane-extracted and sign/zero-extended.
// One request is in flight at most; responses are single-cycle pulses.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned half/word requests respond
//                                      with rsp_err=1 and make no RAM access.
//                         undefined -> low address bits are forced to natural
//                                      alignment and rsp_err is always 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only in idle)
//   req_we              1 = store, 0 = load
//   req_size            0 byte, 1 half, 2/3 word
//   req_unsigned        zero-extend loads
//   req_addr            byte address, bits [AW+1:2] select the RAM word
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           extended load data (0 for stores/errors), held
//   rsp_err             misaligned request flag, held
//   mem_addr/din/we     RAM word address, write data, write enable
//   mem_dout            RAM read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module lsu_dmem_ctrl #(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StData,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Captured request
    logic          we_q;
    logic          byte_q;
    logic          half_q;
    logic          uns_q;
    logic [1:0]    lane_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] mem_addr_q;

    // Response registers
    logic [31:0]   rdata_q;
    logic          err_q;

    // Request decode
    logic          accept;
    logic          in_byte;
    logic          in_half;
    logic          misalign;
    logic [1:0]    lane_in;

    // Datapath
    logic [4:0]    shamt;
    logic [31:0]   lane_mask;
    logic [31:0]   merged;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    // Address bits above the RAM window are intentionally ignored.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    assign in_byte   = (req_size == 2'd0);
    assign in_half   = (req_size == 2'd1);

    always_comb begin
        lane_in  = req_addr[1:0];
        misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (in_half) begin
            misalign = req_addr[0];
        end else if (!in_byte) begin
            misalign = |req_addr[1:0];
        end
`else
        if (in_half) begin
            lane_in[0] = 1'b0;
        end else if (!in_byte) begin
            lane_in = 2'b00;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = misalign ? StResp : StAccess;
                end
            end
            StAccess: begin
                // Word stores write in this cycle; everything else needs read data.
                state_d = (we_q && !byte_q && !half_q) ? StResp : StData;
            end
            StData:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane shift: byte lane * 8; half lanes are 0 or 2 since lane_q[0] is clear.
    assign shamt     = {lane_q, 3'b000};
    assign lane_mask = (byte_q ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
    assign merged    = (mem_dout & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    assign shifted   = mem_dout >> shamt;

    always_comb begin
        load_ext = shifted;
        if (byte_q) begin
            load_ext = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
        end else if (half_q) begin
            load_ext = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
        end
    end

    // RAM-side outputs
    always_comb begin
        mem_we  = 1'b0;
        mem_din = 32'h0;
        unique case (state_q)
            StAccess: begin
                if (we_q && !byte_q && !half_q) begin
                    mem_we  = 1'b1;
                    mem_din = wdata_q;
                end
            end
            StData: begin
                if (we_q) begin
                    mem_we  = 1'b1;
                    mem_din = merged;
                end
            end
            default: ;
        endcase
        // Reset must suppress any write in the same cycle, including a pending RMW.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign rsp_valid = (state_q == StResp) && !rst;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
            mem_addr_q <= '0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                byte_q  <= in_byte;
                half_q  <= in_half;
                uns_q   <= req_unsigned;
                lane_q  <= lane_in;
                wdata_q <= req_wdata;
                if (misalign) begin
                    // Trapped request: respond next cycle, RAM address untouched.
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end else begin
                    mem_addr_q <= req_addr[AW+1:2];
                end
            end
            if (state_q == StAccess && state_d == StResp) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if (state_q == StData) begin
                rdata_q <= we_q ? 32'h0 : load_ext;
                err_q   <= 1'b0;
            end
        end
    end

endmodule
